// File: rtl/sdp_bram_ctrl.sv
// Simple-dual-port word buffer: lane-strobed writes, 1/2-cycle reads with rd_valid,
// write-first forwarding on address collision and a sequencer that zeroes the array.
module sdp_bram_ctrl #(
  parameter  int DATA_W         = 128,
  parameter  int LANE_W         = 8,
  parameter  int DEPTH          = 256,
  parameter  int OUT_REG        = 0,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NL             = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NL-1:0]     wr_strb,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_req,
  output logic              busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              wr_fire;
  logic              rd_fire;
  logic              rd_in_range;
  logic [DATA_W-1:0] stored_word;
  logic [DATA_W-1:0] rd_word;

  logic              p0_valid_q, p0_valid_d;
  logic [DATA_W-1:0] p0_data_q, p0_data_d;

  assign idle        = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_CLEAR);
  assign wr_fire     = idle & wr_en & ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_fire     = idle & rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

  // Clear sequencer: a request arriving mid-clear is ignored so the sweep never restarts.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Storage has no reset of its own; only the sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_addr_q] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < NL; i++) begin
          if (wr_strb[i]) begin
            mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // Write-first forwarding, lane by lane, when both ports hit the same word.
  always_comb begin
    stored_word = '0;
    rd_word     = '0;
    if (rd_in_range) begin
      stored_word = mem[rd_addr];
    end else begin
      stored_word = '0;
    end
    for (int i = 0; i < NL; i++) begin
      rd_word[i*LANE_W +: LANE_W] = (wr_fire && (wr_addr == rd_addr) && wr_strb[i]) ?
                                    wr_data[i*LANE_W +: LANE_W] :
                                    stored_word[i*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    p0_valid_d = rd_fire;
    p0_data_d  = p0_data_q;
    if (rd_fire) begin
      p0_data_d = rd_word;
    end else begin
      p0_data_d = p0_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p0_valid_q <= 1'b0;
      p0_data_q  <= '0;
    end else begin
      p0_valid_q <= p0_valid_d;
      p0_data_q  <= p0_data_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              p1_valid_q, p1_valid_d;
      logic [DATA_W-1:0] p1_data_q, p1_data_d;

      always_comb begin
        p1_valid_d = p0_valid_q;
        p1_data_d  = p1_data_q;
        if (p0_valid_q) begin
          p1_data_d = p0_data_q;
        end else begin
          p1_data_d = p1_data_q;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          p1_valid_q <= 1'b0;
          p1_data_q  <= '0;
        end else begin
          p1_valid_q <= p1_valid_d;
          p1_data_q  <= p1_data_d;
        end
      end

      assign rd_valid = p1_valid_q;
      assign rd_data  = p1_data_q;
    end else begin : g_out_direct
      assign rd_valid = p0_valid_q;
      assign rd_data  = p0_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_bram_ctrl.sv
// Directed bench: three instances (1-cycle, 2-cycle, DEPTH=200) share one stimulus stream.
module tb_sdp_bram_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_strb;
  logic         rd_en;
  logic [7:0]   rd_addr;
  logic         clear_req;

  logic [127:0] rd_data_a, rd_data_b, rd_data_c;
  logic         rd_valid_a, rd_valid_b, rd_valid_c;
  logic         busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdp_bram_ctrl #(.DATA_W(128), .LANE_W(8), .DEPTH(256), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .clear_req(clear_req), .busy(busy_a));

  sdp_bram_ctrl #(.DATA_W(128), .LANE_W(8), .DEPTH(256), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .clear_req(clear_req), .busy(busy_b));

  sdp_bram_ctrl #(.DATA_W(128), .LANE_W(8), .DEPTH(200), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c),
    .rd_valid(rd_valid_c), .clear_req(clear_req), .busy(busy_c));

  function automatic logic [127:0] rep(input logic [7:0] b);
    rep = {16{b}};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [127:0] d, input logic [15:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a,
                          input logic [127:0] exp_a, input logic [127:0] exp_c);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check_eq({tag, "_va"}, 128'(rd_valid_a), 128'd1);
    check_eq({tag, "_da"}, rd_data_a, exp_a);
    check_eq({tag, "_vc"}, 128'(rd_valid_c), 128'd1);
    check_eq({tag, "_dc"}, rd_data_c, exp_c);
  endtask

  // Counts busy cycles of instances a and c; bounded so a stuck busy shows as a wrong count.
  task automatic wait_clear(input int pulse_at, output int ca, output int cc, output int bad);
    int k;
    ca = 0; cc = 0; bad = 0; k = 0;
    while ((busy_a || busy_c) && k < 400) begin
      if (busy_a) ca++;
      if (busy_c) cc++;
      clear_req = (k == pulse_at);
      tick();
      if (rd_valid_a) bad++;
      k++;
    end
    clear_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, cc, bad;
    logic [127:0] exp;
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 128'd0; wr_strb = 16'd0;
    rd_en = 1'b0; rd_addr = 8'd0; clear_req = 1'b0;
    repeat (3) tick();

    check_eq("rst_valid_a", 128'(rd_valid_a), 128'd0);
    check_eq("rst_valid_b", 128'(rd_valid_b), 128'd0);
    check_eq("rst_data_a", rd_data_a, 128'd0);
    check_eq("rst_busy_a", 128'(busy_a), 128'd1);
    check_eq("rst_busy_c", 128'(busy_c), 128'd1);

    reset_n = 1'b1;
    wait_clear(-1, ca, cc, bad);
    check_eq("rst_clr_len_a", 128'(ca), 128'd256);
    check_eq("rst_clr_len_c", 128'(cc), 128'd200);

    rd_check("clr_rd0", 8'd0, 128'd0, 128'd0);
    rd_check("clr_rd128", 8'd128, 128'd0, 128'd0);
    rd_check("clr_rd255", 8'd255, 128'd0, 128'd0);

    // Strobed writes, including an all-zero strobe that must change nothing.
    wr(8'd5, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF);
    wr(8'd5, rep(8'hAA), 16'h00F0);
    exp = 128'h0F0E0D0C0B0A0908AAAAAAAA03020100;
    rd_check("strb", 8'd5, exp, exp);
    wr(8'd5, rep(8'hFF), 16'h0000);
    rd_check("strb_zero", 8'd5, exp, exp);

    // Same-cycle write and read of one word.
    wr(8'd9, rep(8'h11), 16'hFFFF);
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = rep(8'h55); wr_strb = 16'h000F;
    rd_en = 1'b1; rd_addr = 8'd9;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    exp = rep(8'h11);
    exp[31:0] = 32'h55555555;
    check_eq("coll_v", 128'(rd_valid_a), 128'd1);
    check_eq("coll_d", rd_data_a, exp);
    rd_check("coll_again", 8'd9, exp, exp);

    // Back-to-back reads: a answers one edge after accept, b two.
    for (int i = 0; i < 8; i++) wr(8'(i), rep(8'h30 + 8'(i)), 16'hFFFF);
    for (int k = 1; k <= 10; k++) begin
      rd_en = (k <= 8);
      rd_addr = 8'(k - 1);
      tick();
      check_eq($sformatf("thr_va_%0d", k), 128'(rd_valid_a), 128'(k <= 8));
      if (k <= 8) check_eq($sformatf("thr_da_%0d", k), rd_data_a, rep(8'h30 + 8'(k - 1)));
      check_eq($sformatf("thr_vb_%0d", k), 128'(rd_valid_b), 128'(k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) check_eq($sformatf("thr_db_%0d", k), rd_data_b, rep(8'h30 + 8'(k - 2)));
    end
    rd_en = 1'b0;

    // Clear requested alongside a write+read of address 3; traffic during busy is blocked.
    clear_req = 1'b1;
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = rep(8'h77); wr_strb = 16'hFFFF;
    rd_en = 1'b1; rd_addr = 8'd3;
    tick();
    clear_req = 1'b0;
    check_eq("mid_fwd_v", 128'(rd_valid_a), 128'd1);
    check_eq("mid_fwd_d", rd_data_a, rep(8'h77));
    check_eq("mid_busy", 128'(busy_a), 128'd1);
    wr_addr = 8'd4; wr_data = rep(8'h99); rd_addr = 8'd4;
    tick();
    check_eq("mid_inflight_vb", 128'(rd_valid_b), 128'd1);
    check_eq("mid_inflight_db", rd_data_b, rep(8'h77));
    check_eq("mid_blocked_va", 128'(rd_valid_a), 128'd0);
    wait_clear(-1, ca, cc, bad);
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("mid_clr_len_a", 128'(ca), 128'd255);
    check_eq("mid_clr_len_c", 128'(cc), 128'd199);
    check_eq("mid_no_valid", 128'(bad), 128'd0);
    rd_check("mid_rd3", 8'd3, 128'd0, 128'd0);
    rd_check("mid_rd4", 8'd4, 128'd0, rep(8'h99));

    // Reset at clear cycle 100 restarts the sweep; a second clear_req mid-sweep is ignored.
    wr(8'd10, rep(8'h5A), 16'hFFFF);
    rd_check("pre_rst", 8'd10, rep(8'h5A), rep(8'h5A));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (100) tick();
    check_eq("hold_rd_data", rd_data_a, rep(8'h5A));
    check_eq("hold_busy", 128'(busy_a), 128'd1);
    reset_n = 1'b0;
    tick();
    check_eq("mrst_data_a", rd_data_a, 128'd0);
    check_eq("mrst_busy_a", 128'(busy_a), 128'd1);
    reset_n = 1'b1;
    wait_clear(50, ca, cc, bad);
    check_eq("mrst_len_a", 128'(ca), 128'd256);
    check_eq("mrst_len_c", 128'(cc), 128'd200);
    rd_check("mrst_rd10", 8'd10, 128'd0, 128'd0);

    // Out-of-range for DEPTH=200 (in range for DEPTH=256).
    wr(8'd0, rep(8'hA0), 16'hFFFF);
    wr(8'd199, rep(8'hB1), 16'hFFFF);
    wr(8'd220, rep(8'hFF), 16'hFFFF);
    rd_check("oor_220", 8'd220, rep(8'hFF), 128'd0);
    rd_check("oor_lo", 8'd0, rep(8'hA0), rep(8'hA0));
    rd_check("oor_hi", 8'd199, rep(8'hB1), rep(8'hB1));

    // A read in flight in the 2-cycle pipeline is dropped by reset.
    rd_en = 1'b1; rd_addr = 8'd0;
    tick();
    rd_en = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("inflight_drop_b", 128'(rd_valid_b), 128'd0);
    check_eq("inflight_drop_a", 128'(rd_valid_a), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
